// File: rtl/alu_operand_stage_if.sv
// Decode-to-execute operand bundle.
// Decode drives the sources; execute consumes the operands.
interface alu_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        src_a_sel;
  logic [1:0]        src_b_sel;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   pc;
  logic              ex_wr_en;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_data;
  logic              wb_wr_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   store_data;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output in_valid, src_a_sel, src_b_sel,
    output rs1_addr, rs2_addr,
    output rs1_data, rs2_data, imm, pc,
    output ex_wr_en, ex_rd, ex_data,
    output wb_wr_en, wb_rd, wb_data,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  op_a, op_b, store_data,
    input  fwd_a, fwd_b
  );

  modport slave (
    input  in_valid, src_a_sel, src_b_sel,
    input  rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, imm, pc,
    input  ex_wr_en, ex_rd, ex_data,
    input  wb_wr_en, wb_rd, wb_data,
    input  flush, out_ready,
    output in_ready, out_valid,
    output op_a, op_b, store_data,
    output fwd_a, fwd_b
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand select + EX/WB forwarding,
// held in a one-entry valid/ready register.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int PC_INC = 4
) (
  input logic clk,
  input logic rst,
  alu_operand_stage_if.slave bus
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  localparam logic [XLEN-1:0] INC_K =
    XLEN'(PC_INC);

  logic            take;
  logic [XLEN-1:0] rs1_v;
  logic [XLEN-1:0] rs2_v;
  logic [1:0]      rs1_src;
  logic [1:0]      rs2_src;
  logic [XLEN-1:0] a_nxt;
  logic [XLEN-1:0] b_nxt;
  logic [1:0]      fa_nxt;
  logic [1:0]      fb_nxt;

  assign bus.in_ready =
    !bus.out_valid || bus.out_ready;
  assign take = bus.in_valid && bus.in_ready;

  // Forwarded register values, EX before WB, x0 never forwarded
  always_comb begin
    rs1_v   = bus.rs1_data;
    rs1_src = FWD_NONE;
    rs2_v   = bus.rs2_data;
    rs2_src = FWD_NONE;
    if (bus.rs1_addr != '0) begin
      if (bus.ex_wr_en &&
          bus.ex_rd == bus.rs1_addr) begin
        rs1_v   = bus.ex_data;
        rs1_src = FWD_EX;
      end else if (bus.wb_wr_en &&
                   bus.wb_rd == bus.rs1_addr) begin
        rs1_v   = bus.wb_data;
        rs1_src = FWD_WB;
      end
    end
    if (bus.rs2_addr != '0) begin
      if (bus.ex_wr_en &&
          bus.ex_rd == bus.rs2_addr) begin
        rs2_v   = bus.ex_data;
        rs2_src = FWD_EX;
      end else if (bus.wb_wr_en &&
                   bus.wb_rd == bus.rs2_addr) begin
        rs2_v   = bus.wb_data;
        rs2_src = FWD_WB;
      end
    end
  end

  // Operand muxes; forwarding tag only on register picks
  always_comb begin
    a_nxt  = '0;
    fa_nxt = FWD_NONE;
    b_nxt  = '0;
    fb_nxt = FWD_NONE;
    unique case (bus.src_a_sel)
      2'b00: begin
        a_nxt  = rs1_v;
        fa_nxt = rs1_src;
      end
      2'b01: a_nxt = bus.imm;
      2'b10: a_nxt = bus.pc;
      2'b11: a_nxt = '0;
    endcase
    unique case (bus.src_b_sel)
      2'b00: begin
        b_nxt  = rs2_v;
        fb_nxt = rs2_src;
      end
      2'b01: b_nxt = bus.imm;
      2'b10: b_nxt = INC_K;
      2'b11: b_nxt = '0;
    endcase
  end

  // Output register: reset > flush > capture/consume > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.op_a       <= '0;
      bus.op_b       <= '0;
      bus.store_data <= '0;
      bus.fwd_a      <= FWD_NONE;
      bus.fwd_b      <= FWD_NONE;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (bus.in_ready) begin
      bus.out_valid <= bus.in_valid;
      if (take) begin
        bus.op_a       <= a_nxt;
        bus.op_b       <= b_nxt;
        bus.store_data <= rs2_v;
        bus.fwd_a      <= fa_nxt;
        bus.fwd_b      <= fb_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed + random bench for alu_operand_stage
// against a behavioural operand model.
module tb_alu_operand_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_operand_stage_if #(
    .XLEN(XLEN), .REG_AW(AW)
  ) bus ();

  alu_operand_stage #(
    .XLEN(XLEN), .REG_AW(AW), .PC_INC(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic        m_v;
  logic        m_known;
  logic [31:0] m_a, m_b, m_s;
  logic [1:0]  m_fa, m_fb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  // Value a register source resolves to, with its origin
  function automatic logic [33:0] resolve(
    input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && bus.ex_wr_en && bus.ex_rd == a)
      return {2'd1, bus.ex_data};
    if (a != 0 && bus.wb_wr_en && bus.wb_rd == a)
      return {2'd2, bus.wb_data};
    return {2'd0, d};
  endfunction

  task automatic idle();
    bus.in_valid  = 0;
    bus.src_a_sel = 0; bus.src_b_sel = 0;
    bus.rs1_addr  = 0; bus.rs2_addr  = 0;
    bus.rs1_data  = 0; bus.rs2_data  = 0;
    bus.imm = 0; bus.pc = 0;
    bus.ex_wr_en = 0; bus.ex_rd = 0;
    bus.ex_data = 0;
    bus.wb_wr_en = 0; bus.wb_rd = 0;
    bus.wb_data = 0;
    bus.flush = 0; bus.out_ready = 1;
  endtask

  task automatic rand_in();
    bus.src_a_sel = 2'($urandom_range(0, 3));
    bus.src_b_sel = 2'($urandom_range(0, 3));
    bus.rs1_addr  = 5'($urandom_range(0, 3));
    bus.rs2_addr  = 5'($urandom_range(0, 3));
    bus.rs1_data  = $urandom;
    bus.rs2_data  = $urandom;
    bus.imm       = $urandom;
    bus.pc        = $urandom;
    bus.ex_wr_en  = 1'($urandom_range(0, 1));
    bus.ex_rd     = 5'($urandom_range(0, 3));
    bus.ex_data   = $urandom;
    bus.wb_wr_en  = 1'($urandom_range(0, 1));
    bus.wb_rd     = 5'($urandom_range(0, 3));
    bus.wb_data   = $urandom;
  endtask

  // One clock: predict from present inputs, then compare
  task automatic step();
    logic [33:0] r1, r2;
    logic [31:0] ca[4];
    logic [31:0] cb[4];
    logic [1:0]  sa, sb;
    logic        nv, nk;
    logic [31:0] na, nb, ns;
    logic [1:0]  nfa, nfb;
    r1 = resolve(bus.rs1_addr, bus.rs1_data);
    r2 = resolve(bus.rs2_addr, bus.rs2_data);
    ca = '{r1[31:0], bus.imm, bus.pc, 32'd0};
    cb = '{r2[31:0], bus.imm, 32'd4, 32'd0};
    sa = bus.src_a_sel;
    sb = bus.src_b_sel;
    nv = m_v; nk = m_known;
    na = m_a; nb = m_b; ns = m_s;
    nfa = m_fa; nfb = m_fb;
    if (rst) begin
      nv = 0; nk = 1;
      na = 0; nb = 0; ns = 0;
      nfa = 0; nfb = 0;
    end else if (bus.flush) begin
      nv = 0;
    end else if (!m_v || bus.out_ready) begin
      nv = bus.in_valid;
      if (bus.in_valid) begin
        nk  = 1;
        na  = ca[sa];
        nb  = cb[sb];
        ns  = r2[31:0];
        nfa = (sa == 0) ? r1[33:32] : 2'd0;
        nfb = (sb == 0) ? r2[33:32] : 2'd0;
      end else begin
        nk = 0;
      end
    end
    @(posedge clk);
    #1;
    m_v = nv; m_known = nk;
    m_a = na; m_b = nb; m_s = ns;
    m_fa = nfa; m_fb = nfb;
    chk("out_valid", 32'(bus.out_valid),
        32'(m_v));
    chk("in_ready", 32'(bus.in_ready),
        32'(!m_v || bus.out_ready));
    if (m_known) begin
      chk("op_a", bus.op_a, m_a);
      chk("op_b", bus.op_b, m_b);
      chk("store_data", bus.store_data, m_s);
      chk("fwd_a", 32'(bus.fwd_a), 32'(m_fa));
      chk("fwd_b", 32'(bus.fwd_b), 32'(m_fb));
    end
  endtask

  initial begin
    m_v = 0; m_known = 0;
    m_a = 0; m_b = 0; m_s = 0;
    m_fa = 0; m_fb = 0;
    idle();
    rst = 1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_op_a", bus.op_a, 0);
    rst = 0;

    // Plain rs1 + immediate
    bus.in_valid  = 1;
    bus.rs1_data  = 32'h11;
    bus.src_b_sel = 2'b01;
    bus.imm       = 32'hFFFF_FFF0;
    step();
    chk("t1_op_a", bus.op_a, 32'h11);
    chk("t1_op_b", bus.op_b, 32'hFFFF_FFF0);

    // EX beats WB, then WB alone
    bus.rs1_addr = 5;
    bus.ex_wr_en = 1; bus.ex_rd = 5;
    bus.ex_data  = 32'hAAAA;
    bus.wb_wr_en = 1; bus.wb_rd = 5;
    bus.wb_data  = 32'hBBBB;
    step();
    chk("t2_ex", bus.op_a, 32'hAAAA);
    chk("t2_fa", 32'(bus.fwd_a), 1);
    bus.ex_wr_en = 0;
    step();
    chk("t2_wb", bus.op_a, 32'hBBBB);
    chk("t2_fb", 32'(bus.fwd_a), 2);

    // x0 never forwarded
    idle();
    bus.in_valid = 1;
    bus.ex_wr_en = 1; bus.ex_rd = 0;
    bus.ex_data  = 32'h1234;
    step();
    chk("t3_op_b", bus.op_b, 0);
    chk("t3_st", bus.store_data, 0);
    chk("t3_fwd_b", 32'(bus.fwd_b), 0);
    bus.src_a_sel = 2'b10;
    bus.src_b_sel = 2'b10;
    bus.pc = 32'h100;
    step();
    chk("t3_pc", bus.op_a, 32'h100);
    chk("t3_inc", bus.op_b, 4);

    // Stall for three cycles with moving inputs
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step();
      chk("t4_hold", bus.op_a, 32'h100);
    end
    bus.out_ready = 1;
    bus.src_a_sel = 2'b01;
    bus.imm = 32'hCAFE_0001;
    step();
    chk("t4_load_v", 32'(bus.out_valid), 1);
    chk("t4_load", bus.op_a, 32'hCAFE_0001);

    // Flush over a stalled valid entry
    bus.out_ready = 0;
    bus.flush = 1;
    step();
    chk("t5_flush", 32'(bus.out_valid), 0);
    bus.flush = 0;
    bus.imm = 32'h0000_5555;
    step();
    chk("t5_after", bus.op_a, 32'h5555);

    // Reset in the middle of a stall
    step();
    rst = 1;
    step();
    rst = 0;
    chk("t6_v", 32'(bus.out_valid), 0);
    chk("t6_st", bus.store_data, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 9) == 0);
      rst           = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0;

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end
endmodule
